// File: rtl/sub_bytes_engine.sv
// Iterative AES SubBytes / InvSubBytes: substitutes a 128-bit state LANES bytes per cycle.
// Handshake: a transfer happens on a rising edge where valid && ready; valid holds until then.
module sub_bytes_engine #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy,
    output logic [1:0]   dbg_state_o
);

    localparam int GROUPS = 16 / LANES;
    localparam int CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int GRP_W  = 8 * LANES;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(GROUPS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_engine: LANES must be 1, 2, 4, 8 or 16");
    end

    // Entry n of each table lives at bits [8n:8n+7].
    localparam logic [0:2047] FWD_TBL = {
        256'h637c777bf26b6fc53001672bfed7ab76ca82c97dfa5947f0add4a2af9ca472c0,
        256'hb7fd9326363ff7cc34a5e5f171d8311504c723c31896059a071280e2eb27b275,
        256'h09832c1a1b6e5aa0523bd6b329e32f8453d100ed20fcb15b6acbbe394a4c58cf,
        256'hd0efaafb434d338545f9027f503c9fa851a3408f929d38f5bcb6da2110fff3d2,
        256'hcd0c13ec5f974417c4a77e3d645d197360814fdc222a908846eeb814de5e0bdb,
        256'he0323a0a4906245cc2d3ac629195e479e7c8376d8dd54ea96c56f4ea657aae08,
        256'hba78252e1ca6b4c6e8dd741f4bbd8b8a703eb5664803f60e613557b986c11d9e,
        256'he1f8981169d98e949b1e87e9ce5528df8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [0:2047] INV_TBL = {
        256'h52096ad53036a538bf40a39e81f3d7fb7ce339829b2fff87348e4344c4dee9cb,
        256'h547b9432a6c2233dee4c950b42fac34e082ea16628d924b2765ba2496d8bd125,
        256'h72f8f66486689816d4a45ccc5d65b6926c704850fdedb9da5e154657a78d9d84,
        256'h90d8ab008cbcd30af7e45805b8b34506d02c1e8fca3f0f02c1afbd0301138a6b,
        256'h3a9111414f67dcea97f2cfcef0b4e67396ac7422e7ad3585e2f937e81c75df6e,
        256'h47f11a711d29c5896fb7620eaa18be1bfc563e4bc6d279209adbc0fe78cd5af4,
        256'h1fdda8338807c731b11210592780ec5f60517fa919b54a0d2de57a9f93c99cef,
        256'ha0e03b4dae2af5b0c8ebbb3c83539961172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] fwd_sbox(input logic [7:0] b);
        return FWD_TBL[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return INV_TBL[{b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [0:127]       st_q, st_d;
    logic               inv_q, inv_d;
    logic [0:GRP_W-1]   grp_in;
    logic [0:GRP_W-1]   grp_out;

    // Select the group of bytes being substituted this cycle.
    always_comb begin
        grp_in = '0;
        for (int g = 0; g < GROUPS; g++) begin
            if (cnt_q == CNT_W'(g)) begin
                grp_in = st_q[g*GRP_W +: GRP_W];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [7:0] b_in;
        logic [7:0] fwd_out;
        assign b_in    = grp_in[8*l +: 8];
        assign fwd_out = fwd_sbox(b_in);
        if (INV_EN != 0) begin : g_inv
            logic [7:0] inv_out;
            assign inv_out = inv_sbox(b_in);
            assign grp_out[8*l +: 8] = inv_q ? inv_out : fwd_out;
        end else begin : g_fwd
            assign grp_out[8*l +: 8] = fwd_out;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        st_d    = st_q;
        inv_d   = inv_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    inv_d   = in_inv & (INV_EN != 0);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int g = 0; g < GROUPS; g++) begin
                    if (cnt_q == CNT_W'(g)) begin
                        st_d[g*GRP_W +: GRP_W] = grp_out;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            st_q    <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            st_q    <= st_d;
            inv_q   <= inv_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign busy        = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_data    = st_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// Bench for sub_bytes_engine: four configurations, directed FIPS-197 vectors and random blocks
// checked against an S-box model derived from GF(2^8) arithmetic.
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         rst_n     [4];
    logic         in_valid  [4];
    logic         in_ready  [4];
    logic [0:127] in_data   [4];
    logic         in_inv    [4];
    logic         out_valid [4];
    logic         out_ready [4];
    logic [0:127] out_data  [4];
    logic         busy      [4];
    logic [1:0]   dbg_state [4];

    int n_pass = 0;
    int n_checks = 0;

    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    localparam int LAT [4] = '{4, 16, 1, 4};
    localparam bit HAS_INV [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    sub_bytes_engine #(.LANES(4), .INV_EN(1)) u_l4 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_inv(in_inv[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0]),
        .dbg_state_o(dbg_state[0]));
    sub_bytes_engine #(.LANES(1), .INV_EN(1)) u_l1 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_inv(in_inv[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1]),
        .dbg_state_o(dbg_state[1]));
    sub_bytes_engine #(.LANES(16), .INV_EN(1)) u_l16 (
        .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_data(in_data[2]), .in_inv(in_inv[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_data(out_data[2]), .busy(busy[2]),
        .dbg_state_o(dbg_state[2]));
    sub_bytes_engine #(.LANES(4), .INV_EN(0)) u_fwd (
        .clk(clk), .rst_n(rst_n[3]), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_data(in_data[3]), .in_inv(in_inv[3]), .out_valid(out_valid[3]),
        .out_ready(out_ready[3]), .out_data(out_data[3]), .busy(busy[3]),
        .dbg_state_o(dbg_state[3]));

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        return (x << n) | (x >> (8 - n));
    endfunction

    task automatic build_model();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            fwd_m[x] = s;
            inv_m[s] = 8'(x);
        end
    endtask

    function automatic logic [0:127] model_block(input logic [0:127] d, input logic inv);
        logic [0:127] r;
        for (int k = 0; k < 16; k++) begin
            r[8*k +: 8] = inv ? inv_m[d[8*k +: 8]] : fwd_m[d[8*k +: 8]];
        end
        return r;
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        assert (got === exp) n_pass = n_pass + 1;
        else begin
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Offers a block at a negedge; returns DUT output and edges from acceptance to out_valid.
    task automatic send_block(input int d, input logic [0:127] data, input logic inv,
                              output logic [0:127] got, output int lat);
        @(negedge clk);
        in_data[d]  = data;
        in_inv[d]   = inv;
        in_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        in_data[d]  = ~data;
        in_inv[d]   = ~inv;
        lat = 0;
        while (!out_valid[d] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        got = out_data[d];
    endtask

    task automatic drain(input int d);
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
    endtask

    task automatic run_checked(input int d, input string tag, input logic [0:127] data,
                               input logic inv, input logic [0:127] exp);
        logic [0:127] got;
        int lat;
        send_block(d, data, inv, got, lat);
        check({tag, "_lat"}, 128'(lat), 128'(LAT[d]));
        check({tag, "_data"}, got, exp);
        drain(d);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [0:127] got, a_blk, b_blk, held;
        logic [0:127] rnd;
        logic inv;
        int lat;
        bit saw_valid;

        build_model();
        for (int d = 0; d < 4; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = '0;
            in_inv[d] = 1'b0; out_ready[d] = 1'b0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_in_ready", 128'(in_ready[0]), 128'(1));
        check("rst_out_valid", 128'(out_valid[0]), 128'(0));
        check("rst_busy", 128'(busy[0]), 128'(0));
        check("rst_out_data", out_data[0], 128'h0);
        for (int d = 0; d < 4; d++) rst_n[d] = 1'b1;
        @(negedge clk);

        // FIPS-197 vectors
        run_checked(0, "fips_fwd_l4", 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
                    128'hd42711aee0bf98f1b8b45de51e415230);
        run_checked(1, "fips_inv_l1", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808);
        run_checked(2, "fips_inv_l16", 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
                    128'h193de3bea0f4e22b9ac68d2ae9f84808);

        // Point values
        run_checked(0, "zero_fwd", 128'h0, 1'b0, {16{8'h63}});
        run_checked(0, "ff_fwd", {16{8'hff}}, 1'b0, {16{8'h16}});
        run_checked(0, "b53_fwd", {8'h53, {15{8'h00}}}, 1'b0, {8'hed, {15{8'h63}}});
        run_checked(0, "63_inv", {16{8'h63}}, 1'b1, 128'h0);
        run_checked(3, "noinv_zero", 128'h0, 1'b1, {16{8'h63}});

        // Backpressure: hold DONE for 10 cycles while a second block is offered
        a_blk = {$urandom, $urandom, $urandom, $urandom};
        b_blk = {$urandom, $urandom, $urandom, $urandom};
        send_block(0, a_blk, 1'b0, held, lat);
        check("bp_a_data", held, model_block(a_blk, 1'b0));
        in_data[0] = b_blk; in_inv[0] = 1'b1; in_valid[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_stable", out_data[0], held);
            check("bp_valid", 128'(out_valid[0]), 128'(1));
            check("bp_in_ready", 128'(in_ready[0]), 128'(0));
        end
        out_ready[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[0] = 1'b0;
        check("bp_rel_ready", 128'(in_ready[0]), 128'(1));
        check("bp_rel_valid", 128'(out_valid[0]), 128'(0));
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        check("bp_b_busy", 128'(busy[0]), 128'(1));
        check("bp_b_in_ready", 128'(in_ready[0]), 128'(0));
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("bp_b_lat", 128'(lat), 128'(4));
        check("bp_b_data", out_data[0], model_block(b_blk, 1'b1));
        drain(0);

        // Reset in the middle of a LANES=1 block
        @(negedge clk);
        in_data[1] = {16{8'h5a}}; in_inv[1] = 1'b0; in_valid[1] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[1] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy_before", 128'(busy[1]), 128'(1));
        #2 rst_n[1] = 1'b0;
        #1;
        check("mid_rst_busy", 128'(busy[1]), 128'(0));
        check("mid_rst_ready", 128'(in_ready[1]), 128'(1));
        check("mid_rst_valid", 128'(out_valid[1]), 128'(0));
        check("mid_rst_data", out_data[1], 128'h0);
        @(negedge clk);
        rst_n[1] = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid[1] || busy[1]) saw_valid = 1'b1;
        end
        check("mid_rst_no_output", 128'(saw_valid), 128'(0));
        check("mid_rst_data_after", out_data[1], 128'h0);

        // Random blocks with random mode on every configuration
        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 8; i++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                inv = 1'($urandom_range(0, 1));
                run_checked(d, $sformatf("rand_d%0d_%0d", d, i), rnd, inv,
                            model_block(rnd, inv & HAS_INV[d]));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
